fpmult_issue_arbiter: RTL and testbench

Round-robin issue arbiter that shares one pipelined FPMult datapath (the fixed-latency split-mantissa multiply/normalize pipeline) between several requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the winner into the multiplier. A tag pipeline matched to the multiplier latency routes each result back to the requester that issued it. Per-requester outstanding-operation counters bound the in-flight work of each requester.

---
 rtl/fpmult_issue_arbiter.sv | 146 ++++++++++++++
 tb/tb_fpmult_issue_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FPMult pipeline between NUM_REQ requesters.
// Optional build macro FPMULT_ARB_PRIO0_EN: requester 0 gets strict priority over the round-robin group.

module fpmult_arb_lane #(
  parameter int MAX_OUT = 3,
  parameter int CNTW    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic issue_i,
  input  logic retire_i,
  output logic elig_o
);
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Issue and retire in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (issue_i && !retire_i)      cnt_d = cnt_q + 1'b1;
    else if (!issue_i && retire_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign elig_o = valid_i && (cnt_q < CNTW'(MAX_OUT));
endmodule

module fpmult_issue_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 4,
  parameter int MAX_OUT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      mul_valid,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_result,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic                      busy
);
  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(MAX_OUT + 1);

  logic [NUM_REQ-1:0]   elig, rr_elig, grant, retire;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d, rr_id, gnt_id;
  logic                 rr_found, gnt_any, adv_ptr;
  logic [2*NUM_REQ-1:0] rot;
  int                   sel_off, idx;

  // Stage 0 mirrors mul_valid; stage PIPE_LAT lines up with mul_result.
  logic [PIPE_LAT:0]          vld_pipe_q;
  logic [PIPE_LAT:0][IDW-1:0] id_pipe_q;

  logic [DATA_W-1:0]  mul_a_q, mul_b_q, res_data_q;
  logic [NUM_REQ-1:0] res_valid_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    fpmult_arb_lane #(.MAX_OUT(MAX_OUT), .CNTW(CNTW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (req_valid[g]),
      .issue_i  (grant[g]),
      .retire_i (retire[g]),
      .elig_o   (elig[g])
    );
  end

`ifdef FPMULT_ARB_PRIO0_EN
  assign rr_elig = elig & ~NUM_REQ'(1);
`else
  assign rr_elig = elig;
`endif

  // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit.
  always_comb begin
    rot      = {rr_elig, rr_elig} >> rr_ptr_q;
    sel_off  = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--)
      if (rot[off]) sel_off = off;
    rr_found = |rot[NUM_REQ-1:0];
    idx      = sel_off + int'(rr_ptr_q);
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    rr_id    = IDW'(idx);
  end

  always_comb begin
    gnt_any = rr_found;
    gnt_id  = rr_id;
    adv_ptr = rr_found;
`ifdef FPMULT_ARB_PRIO0_EN
    if (elig[0]) begin
      gnt_any = 1'b1;
      gnt_id  = '0;
      adv_ptr = 1'b0;
    end
`endif
    gnt_any  = gnt_any && rst;
    adv_ptr  = adv_ptr && gnt_any;
    rr_ptr_d = rr_ptr_q;
    if (adv_ptr) rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    grant = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
  end

  assign retire = vld_pipe_q[PIPE_LAT] ? (NUM_REQ'(1) << id_pipe_q[PIPE_LAT]) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      vld_pipe_q <= {vld_pipe_q[PIPE_LAT-1:0], gnt_any};
      id_pipe_q  <= {id_pipe_q[PIPE_LAT-1:0], gnt_id};
      if (gnt_any) begin
        mul_a_q <= req_a[gnt_id*DATA_W +: DATA_W];
        mul_b_q <= req_b[gnt_id*DATA_W +: DATA_W];
      end
      res_valid_q <= retire;
      if (vld_pipe_q[PIPE_LAT]) res_data_q <= mul_result;
    end
  end

  assign req_ready = grant;
  assign mul_valid = vld_pipe_q[0];
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = |vld_pipe_q;
endmodule

// File: tb/tb_fpmult_issue_arbiter.sv
// Directed bench for fpmult_issue_arbiter with a 4-cycle toy FP multiplier model.
module tb_fpmult_issue_arbiter;
  localparam int NR = 4, DW = 32, PL = 4, MO = 3;
  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000, F6 = 32'h40C00000, F8 = 32'h41000000;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req_valid, req_ready, res_valid;
  logic [NR*DW-1:0] req_a, req_b;
  logic mul_valid, busy;
  logic [DW-1:0] mul_a, mul_b, mul_result, res_data;
  logic [DW-1:0] mpipe [PL];
  logic [31:0] fv [NR];
  logic [31:0] pv [NR];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  fpmult_issue_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(PL), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .res_valid(res_valid), .res_data(res_data), .busy(busy));

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0] e;
    logic s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  // Multiplier model: never reset, keeps producing results after a DUT reset.
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < PL; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[PL-1];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = fv[i];
      req_b[i*DW +: DW] = F2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '1;
    load_ops();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL reset_mul_valid got %b exp 0", mul_valid); end
    checks++; if (mul_a !== 32'h0) begin errors++; $display("FAIL reset_mul_a got %h exp 0", mul_a); end
    checks++; if (res_valid !== 4'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0000", res_valid); end
    checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data got %h exp 0", res_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    logic [NR-1:0] er, ev;
    do_reset();
    req_a[2*DW +: DW] = F2;
    req_b[2*DW +: DW] = F3;
    for (int t = 0; t < 8; t++) begin
      req_valid = (t == 0) ? 4'b0100 : 4'b0000;
      #1;
      er = (t == 0) ? 4'b0100 : 4'b0000;
      ev = (t == 6) ? 4'b0100 : 4'b0000;
      checks++; if (req_ready !== er) begin errors++; $display("FAIL single_ready t=%0d got %b exp %b", t, req_ready, er); end
      checks++; if (mul_valid !== (t == 1)) begin errors++; $display("FAIL single_mul_valid t=%0d got %b", t, mul_valid); end
      checks++; if (res_valid !== ev) begin errors++; $display("FAIL single_res_valid t=%0d got %b exp %b", t, res_valid, ev); end
      if (t == 1) begin
        checks++; if (mul_a !== F2 || mul_b !== F3) begin errors++; $display("FAIL single_operands got %h %h exp %h %h", mul_a, mul_b, F2, F3); end
      end
      if (t == 6) begin
        checks++; if (res_data !== F6) begin errors++; $display("FAIL single_res_data got %h exp %h", res_data, F6); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] er, ev;
    logic eb;
    do_reset();
    load_ops();
    for (int t = 0; t < 16; t++) begin
      req_valid = (t < 8) ? 4'b1111 : 4'b0000;
      #1;
      er = (t < 8) ? (4'b0001 << (t % 4)) : 4'b0000;
      ev = (t >= 6 && t < 14) ? (4'b0001 << ((t - 6) % 4)) : 4'b0000;
      eb = (t >= 1 && t <= 12);
      checks++; if (req_ready !== er) begin errors++; $display("FAIL rr_ready t=%0d got %b exp %b", t, req_ready, er); end
      checks++; if (res_valid !== ev) begin errors++; $display("FAIL rr_res_valid t=%0d got %b exp %b", t, res_valid, ev); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL rr_busy t=%0d got %b exp %b", t, busy, eb); end
      if (ev != 4'b0000) begin
        checks++; if (res_data !== pv[(t - 6) % 4]) begin errors++; $display("FAIL rr_res_data t=%0d got %h exp %h", t, res_data, pv[(t - 6) % 4]); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] er, ev;
    do_reset();
    load_ops();
    for (int t = 0; t < 13; t++) begin
      req_valid = 4'b0010;
      #1;
      er = ((t % 6) < 3) ? 4'b0010 : 4'b0000;
      ev = (t >= 6 && (t % 6) < 3) ? 4'b0010 : 4'b0000;
      checks++; if (req_ready !== er) begin errors++; $display("FAIL b2b_ready t=%0d got %b exp %b", t, req_ready, er); end
      checks++; if (res_valid !== ev) begin errors++; $display("FAIL b2b_res_valid t=%0d got %b exp %b", t, res_valid, ev); end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_grant_retire();
    logic [11:0] vmask, gmask, rmask;
    logic [NR-1:0] er, ev;
    vmask = 12'b1111_1110_0011;
    gmask = 12'b1000_1110_0011;
    rmask = 12'b1000_1100_0000;
    do_reset();
    load_ops();
    for (int t = 0; t < 12; t++) begin
      req_valid = vmask[t] ? 4'b0001 : 4'b0000;
      #1;
      er = gmask[t] ? 4'b0001 : 4'b0000;
      ev = rmask[t] ? 4'b0001 : 4'b0000;
      checks++; if (req_ready !== er) begin errors++; $display("FAIL gr_ready t=%0d got %b exp %b", t, req_ready, er); end
      checks++; if (res_valid !== ev) begin errors++; $display("FAIL gr_res_valid t=%0d got %b exp %b", t, res_valid, ev); end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_in_flight();
    logic [NR-1:0] er;
    do_reset();
    load_ops();
    for (int t = 0; t < 3; t++) begin
      req_valid = 4'b0111;
      #1;
      er = 4'b0001 << t;
      checks++; if (req_ready !== er) begin errors++; $display("FAIL rf_ready t=%0d got %b exp %b", t, req_ready, er); end
      tick();
    end
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rf_busy_before got %b exp 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL rf_mul_valid got %b exp 0", mul_valid); end
    checks++; if (mul_a !== 32'h0) begin errors++; $display("FAIL rf_mul_a got %h exp 0", mul_a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rf_busy got %b exp 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 10; t++) begin
      #1;
      checks++; if (res_valid !== 4'b0) begin errors++; $display("FAIL rf_res_after t=%0d got %b exp 0000", t, res_valid); end
      tick();
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rf_first_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_prio();
    logic [NR-1:0] er;
    do_reset();
    load_ops();
    for (int t = 0; t < 12; t++) begin
      req_valid = 4'b1001;
      #1;
`ifdef FPMULT_ARB_PRIO0_EN
      er = ((t % 6) < 3) ? 4'b0001 : 4'b1000;
`else
      er = ((t % 2) == 0) ? 4'b0001 : 4'b1000;
`endif
      checks++; if (req_ready !== er) begin errors++; $display("FAIL prio_ready t=%0d got %b exp %b", t, req_ready, er); end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    fv[0] = F1; fv[1] = F2; fv[2] = F3; fv[3] = F4;
    pv[0] = F2; pv[1] = F4; pv[2] = F6; pv[3] = F8;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_grant_retire();
    test_reset_in_flight();
    test_prio();
    repeat (10) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
